// File: rtl/cplx_mag2_pkg.sv
// Shared width helpers and field sizes for the |X|^2 averaging stage.
package cplx_mag2_pkg;

    localparam int CFG_W = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int mag_w(input int dw);
        return 2 * dw;
    endfunction

    // Room for summing 2^avg_max magnitudes without overflow.
    function automatic int acc_w(input int dw, input int avg_max);
        return 2 * dw + avg_max;
    endfunction

    function automatic int frm_w(input int avg_max);
        return (avg_max > 0) ? avg_max : 1;
    endfunction

endpackage

// File: rtl/cplx_mag2_pipe.sv
// S1-S3 of the power pipeline: register sample, square components, sum to |X|^2.
// Sideband (bin, last, first/final frame flags, shift) travels alongside the data.
module cplx_mag2_pipe
    import cplx_mag2_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_re,
    input  logic [DW-1:0]        in_im,
    input  logic                 in_last,
    input  logic [AW-1:0]        in_bin,
    input  logic                 in_first,
    input  logic                 in_final,
    input  logic [CFG_W-1:0]     in_sh,
    output logic [AW-1:0]        s1_bin,
    output logic                 s3_valid,
    output logic [2*DW-1:0]      s3_mag2,
    output logic                 s3_last,
    output logic [AW-1:0]        s3_bin,
    output logic                 s3_first,
    output logic                 s3_final,
    output logic [CFG_W-1:0]     s3_sh
);

    logic              s1_valid, s2_valid;
    logic [DW-1:0]     s1_re, s1_im;
    logic              s1_last, s1_first, s1_final;
    logic [CFG_W-1:0]  s1_sh, s2_sh;
    logic              s2_last, s2_first, s2_final;
    logic [AW-1:0]     s2_bin;
    logic [2*DW-1:0]   s2_pre, s2_pim;
    logic [2*DW-1:0]   re_x, im_x;

    // Sign-extend so a plain 2DW multiply yields the exact signed square.
    always_comb begin
        re_x = {{DW{s1_re[DW-1]}}, s1_re};
        im_x = {{DW{s1_im[DW-1]}}, s1_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk) begin
        s1_re    <= in_re;
        s1_im    <= in_im;
        s1_last  <= in_last;
        s1_bin   <= in_bin;
        s1_first <= in_first;
        s1_final <= in_final;
        s1_sh    <= in_sh;

        s2_pre   <= re_x * re_x;
        s2_pim   <= im_x * im_x;
        s2_last  <= s1_last;
        s2_bin   <= s1_bin;
        s2_first <= s1_first;
        s2_final <= s1_final;
        s2_sh    <= s1_sh;

        // Both squares are non-negative and <= 2^(2DW-2), so the sum fits unsigned.
        s3_mag2  <= s2_pre + s2_pim;
        s3_last  <= s2_last;
        s3_bin   <= s2_bin;
        s3_first <= s2_first;
        s3_final <= s2_final;
        s3_sh    <= s2_sh;
    end

endmodule

// File: rtl/cplx_mag2_avg.sv
// Streaming power-spectrum stage: |X|^2 per bin, optionally averaged over 2^n frames.
// Top holds bin/frame counters, frame-length error logic, accumulator RAM and S4.
module cplx_mag2_avg
    import cplx_mag2_pkg::*;
#(
    parameter int DW           = 16,
    parameter int FFT_LEN      = 1024,
    parameter int AVG_LOG2_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [CFG_W-1:0]              cfg_avg_log2,
    input  logic [DW-1:0]                 in_re,
    input  logic [DW-1:0]                 in_im,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic [mag_w(DW)-1:0]          out_pwr,
    output logic [clog2(FFT_LEN)-1:0]     out_bin,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          err_frame
);

    localparam int AW    = clog2(FFT_LEN);
    localparam int MAG_W = mag_w(DW);
    localparam int ACC_W = acc_w(DW, AVG_LOG2_MAX);
    localparam int FW    = frm_w(AVG_LOG2_MAX);

    logic [AW-1:0]    bin_cnt;
    logic [FW-1:0]    frm_cnt, frm_last_idx;
    logic [CFG_W-1:0] avg_q, cfg_clamped, avg_eff;
    logic             grp_start, frm_first, frm_final, at_end, accept, len_err;

    logic [AW-1:0]    s1_bin, s3_bin;
    logic             s3_valid, s3_last, s3_first, s3_final;
    logic [MAG_W-1:0] s3_mag2;
    logic [CFG_W-1:0] s3_sh;

    logic [ACC_W-1:0] acc_mem [FFT_LEN];
    logic [ACC_W-1:0] rd_q1, rd_q2, acc;

    // The shift for a group is taken at its first sample, so a new cfg takes effect immediately there.
    always_comb begin
        cfg_clamped  = (int'(cfg_avg_log2) > AVG_LOG2_MAX) ? CFG_W'(AVG_LOG2_MAX) : cfg_avg_log2;
        grp_start    = (bin_cnt == '0) && (frm_cnt == '0);
        avg_eff      = grp_start ? cfg_clamped : avg_q;
        frm_last_idx = FW'((32'd1 << avg_eff) - 32'd1);
        frm_first    = (frm_cnt == '0);
        frm_final    = (frm_cnt == frm_last_idx);
        at_end       = (bin_cnt == AW'(FFT_LEN - 1));
        accept       = in_valid && !clr;
        len_err      = accept && (in_last != at_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt   <= '0;
            frm_cnt   <= '0;
            avg_q     <= '0;
            err_frame <= 1'b0;
        end else if (clr) begin
            bin_cnt   <= '0;
            frm_cnt   <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= len_err;
            if (accept) begin
                if (grp_start) avg_q <= cfg_clamped;
                if (len_err) begin
                    bin_cnt <= '0;
                    frm_cnt <= '0;
                end else if (in_last) begin
                    bin_cnt <= '0;
                    frm_cnt <= frm_final ? '0 : frm_cnt + FW'(1);
                end else begin
                    bin_cnt <= bin_cnt + AW'(1);
                end
            end
        end
    end

    cplx_mag2_pipe #(
        .DW (DW),
        .AW (AW)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (accept),
        .in_re    (in_re),
        .in_im    (in_im),
        .in_last  (in_last),
        .in_bin   (bin_cnt),
        .in_first (frm_first),
        .in_final (frm_final),
        .in_sh    (avg_eff),
        .s1_bin   (s1_bin),
        .s3_valid (s3_valid),
        .s3_mag2  (s3_mag2),
        .s3_last  (s3_last),
        .s3_bin   (s3_bin),
        .s3_first (s3_first),
        .s3_final (s3_final),
        .s3_sh    (s3_sh)
    );

    // A bin recurs no sooner than FFT_LEN cycles, well after its write, so no bypass.
    always_ff @(posedge clk) begin
        if (s3_valid) acc_mem[s3_bin] <= acc;
        rd_q1 <= acc_mem[s1_bin];
        rd_q2 <= rd_q1;
    end

    always_comb begin
        acc = s3_first ? ACC_W'(s3_mag2) : rd_q2 + ACC_W'(s3_mag2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pwr   <= '0;
            out_bin   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr || !(s3_valid && s3_final)) begin
            out_pwr   <= '0;
            out_bin   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_pwr   <= MAG_W'(acc >> s3_sh);
            out_bin   <= s3_bin;
            out_valid <= 1'b1;
            out_last  <= s3_last;
        end
    end

endmodule

// File: tb/tb_cplx_mag2_avg.sv
// Bench for cplx_mag2_avg: directed frames plus random gaps/cfg against a frame-level model.
module tb_cplx_mag2_avg;

    localparam int DW      = 16;
    localparam int FFT_LEN = 8;
    localparam int AVG_MAX = 4;
    localparam int AW      = 3;
    localparam int MAG_W   = 32;
    localparam int W       = 2 + AW + MAG_W;

    logic              clk, rst_n, clr, in_valid, in_last;
    logic [2:0]        cfg_avg_log2;
    logic [DW-1:0]     in_re, in_im;
    logic [MAG_W-1:0]  out_pwr;
    logic [AW-1:0]     out_bin;
    logic              out_valid, out_last, err_frame;

    cplx_mag2_avg #(
        .DW           (DW),
        .FFT_LEN      (FFT_LEN),
        .AVG_LOG2_MAX (AVG_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .cfg_avg_log2 (cfg_avg_log2),
        .in_re        (in_re),
        .in_im        (in_im),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .out_pwr      (out_pwr),
        .out_bin      (out_bin),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .err_frame    (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: one entry per driven cycle, {valid, last, bin, pwr}
    logic [W-1:0]     exp_q[$];
    logic             exp_err_q[$];
    int               n_tests, n_fail;
    bit               mon_en;
    logic [MAG_W-1:0] cap_pwr [FFT_LEN];
    int               cap_cnt, err_cnt;
    int               cfg_sel;

    // reference model state
    int     m_bin, m_frm, m_avg;
    longint m_sum [FFT_LEN];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         ee;
        if (mon_en) begin
            if (exp_q.size() < 1 || exp_err_q.size() < 1) begin
                check("queue_empty", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                ee = exp_err_q.pop_front();
                check("out_valid", out_valid, e[W-1]);
                check("out_last", out_last, e[W-2]);
                check("err_frame", err_frame, ee);
                if (err_frame) err_cnt++;
                if (e[W-1]) begin
                    check("out_bin", out_bin, e[MAG_W +: AW]);
                    check("out_pwr", out_pwr, e[MAG_W-1:0]);
                end
                if (out_valid) begin
                    cap_pwr[out_bin] = out_pwr;
                    cap_cnt++;
                end
            end
        end
    end

    // One cycle of stimulus; the model predicts what appears 4 cycles (err: 1 cycle) later.
    task automatic step(input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input bit last, input bit c);
        logic [W-1:0] e;
        logic         ee;
        int           n;
        bit           first, fin;
        longint       sre, sim, mag;
        @(posedge clk);
        #1;
        in_valid     = v;
        in_re        = re;
        in_im        = im;
        in_last      = last;
        clr          = c;
        cfg_avg_log2 = 3'(cfg_sel);
        e  = '0;
        ee = 1'b0;
        if (c) begin
            for (int i = 1; i < exp_q.size(); i++) exp_q[i] = '0;
            m_bin = 0;
            m_frm = 0;
        end else if (v) begin
            if (m_bin == 0 && m_frm == 0) m_avg = (cfg_sel > AVG_MAX) ? AVG_MAX : cfg_sel;
            n     = 1 << m_avg;
            first = (m_frm == 0);
            fin   = (m_frm == n - 1);
            sre   = longint'($signed(re));
            sim   = longint'($signed(im));
            mag   = sre * sre + sim * sim;
            if (first) m_sum[m_bin] = mag;
            else       m_sum[m_bin] = m_sum[m_bin] + mag;
            if (fin) e = {1'b1, last, AW'(m_bin), MAG_W'(m_sum[m_bin] >> m_avg)};
            ee = (last != (m_bin == FFT_LEN - 1));
            if (ee) begin
                m_bin = 0;
                m_frm = 0;
            end else if (last) begin
                m_bin = 0;
                m_frm = fin ? 0 : m_frm + 1;
            end else begin
                m_bin++;
            end
        end
        exp_q.push_back(e);
        exp_err_q.push_back(ee);
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cyc);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pwr", out_pwr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_err_frame", err_frame, 0);
        repeat (cyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_err_q.delete();
        repeat (5) exp_q.push_back('0);
        repeat (2) exp_err_q.push_back(1'b0);
        m_bin  = 0;
        m_frm  = 0;
        mon_en = 1'b1;
    endtask

    task automatic rand_frame(input int idle_pct);
        for (int b = 0; b < FFT_LEN; b++) begin
            while (int'($urandom_range(0, 99)) < idle_pct) idle(1);
            step(1'b1, DW'($urandom), DW'($urandom), b == FFT_LEN - 1, 1'b0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 0; cap_cnt = 0; err_cnt = 0;
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_re = '0; in_im = '0; cfg_avg_log2 = '0; cfg_sel = 0;
        m_bin = 0; m_frm = 0; m_avg = 0;
        do_reset(2);

        // pass-through, re=k im=-k
        cap_cnt = 0;
        for (int k = 0; k < FFT_LEN; k++) step(1'b1, DW'(k), DW'(-k), k == FFT_LEN - 1, 1'b0);
        idle(5);
        check("t1_cnt", cap_cnt, 8);
        check("t1_bin5", cap_pwr[5], 50);
        check("t1_bin7", cap_pwr[7], 98);

        // max magnitude
        for (int k = 0; k < FFT_LEN; k++)
            step(1'b1, (k == 0) ? 16'h8000 : 16'h0, (k == 0) ? 16'h8000 : 16'h0, k == FFT_LEN - 1, 1'b0);
        idle(5);
        check("t2_max", cap_pwr[0], 32'h8000_0000);

        // average of 4 frames, bin 3 re = 1..4
        cfg_sel = 2;
        cap_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < FFT_LEN; k++)
                step(1'b1, (k == 3) ? DW'(f + 1) : DW'(k), (k == 3) ? '0 : DW'(f), k == FFT_LEN - 1, 1'b0);
            if (f == 2) begin
                idle(5);
                check("t3_no_early", cap_cnt, 0);
            end
        end
        idle(5);
        check("t3_cnt", cap_cnt, 8);
        check("t3_bin3", cap_pwr[3], 7);

        // short frame inside a group restarts it
        err_cnt = 0;
        rand_frame(0);
        for (int k = 0; k < 6; k++) step(1'b1, DW'($urandom), DW'($urandom), k == 5, 1'b0);
        idle(3);
        check("t4_err_pulse", err_cnt, 1);
        cap_cnt = 0;
        for (int f = 0; f < 3; f++) rand_frame(0);
        idle(5);
        check("t4_no_early", cap_cnt, 0);
        rand_frame(0);
        idle(5);
        check("t4_cnt", cap_cnt, 8);

        // random gaps, average of 2
        cfg_sel = 1;
        for (int f = 0; f < 8; f++) rand_frame(30);
        idle(6);

        // async reset mid-frame-2 of an 8-frame group, then a clean group
        cfg_sel = 3;
        rand_frame(0);
        rand_frame(0);
        for (int k = 0; k < 4; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        do_reset(2);
        cap_cnt = 0;
        for (int f = 0; f < 8; f++) rand_frame(10);
        idle(6);
        check("t6_rst_cnt", cap_cnt, 8);

        // clr squashes in-flight outputs and drops a same-cycle sample
        cfg_sel = 0;
        rand_frame(0);
        step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        idle(5);
        cfg_sel = 3;
        rand_frame(0);
        for (int k = 0; k < 3; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        cap_cnt = 0;
        for (int f = 0; f < 8; f++) rand_frame(10);
        idle(6);
        check("t6_clr_cnt", cap_cnt, 8);

        // random cfg (incl. values above the max) and occasional frame errors
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 99) < 15) cfg_sel = int'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 20) idle(1);
            step(1'b1, DW'($urandom), DW'($urandom),
                 ($urandom_range(0, 99) < 4) ? (m_bin != FFT_LEN - 1) : (m_bin == FFT_LEN - 1), 1'b0);
        end
        idle(6);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
